ew_pad_mux: RTL
===============

Name: ew_pad_mux

Overview:
- Parametrised, glitch-free multiplexer that shares one group of Caravel user IO pads between NUM_DESIGNS user designs.
- Successor to the fixed single-design pad/LA mapping used in the wrapper.
- Sits in user_project_wrapper between io_in/io_out/io_oeb and the designs.
- The SoC selects the active design over LA lines. On every switch, the block tristates the pads, holds the outgoing design in reset for a guard interval, then releases the new design.

Parameters:
- NUM_DESIGNS, 4, number of designs sharing the pads (2..15).
- PADS, 9, number of shared pads.
- GUARD_CYCLES, 8, tristate/reset guard length in clocks (>=1).
- SYNC_STAGES, 2, synchroniser depth for LA-driven controls (>=2).
- SEL_W, $clog2(NUM_DESIGNS+1), select width (derived; do not override).

Ports:
- i_clk  in  1  design clock (user_clock2).
- i_reset_n  in  1  asynchronous, active-low reset.
- i_la_invalid  in  1  any LA OENB of this group; 1 = LA not driven by SoC.
- i_sel_lock_a  in  1  select-lock pair; the select is valid only when a != b.
- i_sel_lock_b  in  1  (see i_sel_lock_a).
- i_sel  in  SEL_W  requested design index, from LA.
- i_pad_in  in  PADS  io_in slice.
- o_pad_out  out  PADS  io_out slice.
- o_pad_oeb  out  PADS  io_oeb slice; 1 = input.
- i_dsn_out  in  NUM_DESIGNS*PADS  per-design pad outputs; design d uses bits [d*PADS +: PADS].
- i_dsn_oeb  in  NUM_DESIGNS*PADS  per-design pad OEBs, same packing.
- o_dsn_in  out  NUM_DESIGNS*PADS  per-design pad inputs; 0 for non-active designs.
- o_dsn_reset  out  NUM_DESIGNS  per-design reset, active-high.
- o_active  out  SEL_W  index of the currently active design.
- o_switching  out  1  1 in any state other than ACTIVE.

Behaviour:
- Synchronisation: i_la_invalid, both lock bits and i_sel each pass through a SYNC_STAGES flop chain. Sync flops reset to 0.
- Definition: lock_ok = synced (lock_a != lock_b) && !synced la_invalid.
- States: HALT, SETTLE, ACTIVE, DRAIN. The reset state is HALT.
- Reset values:
  - o_dsn_reset = all 1.
  - o_pad_oeb = all 1.
  - o_pad_out = 0.
  - o_dsn_in = 0.
  - o_active = 0.
  - o_switching = 1.
  - Guard counter = 0.
- HALT:
  - All designs are in reset and the pads are tristated.
  - If lock_ok and synced sel < NUM_DESIGNS: load active <= sel, load counter <= GUARD_CYCLES-1, go to SETTLE.
  - An out-of-range sel keeps the block in HALT.
- SETTLE:
  - Pads stay tristated and all designs stay in reset.
  - The counter decrements each clock.
  - When the counter reaches 0: go to ACTIVE and deassert o_dsn_reset[active] on the same edge.
- ACTIVE:
  - Pad muxing: o_pad_out/o_pad_oeb = the active design's slice; o_dsn_in[active] = i_pad_in.
  - This muxing is combinational from the registered active index and state. No added latency; glitch-free because the index changes only while the pads are tristated.
  - If !lock_ok: go to HALT and assert all resets on that edge.
  - Else if synced sel != active and sel < NUM_DESIGNS: go to DRAIN, assert o_dsn_reset[active], load counter <= GUARD_CYCLES-1.
  - An out-of-range sel is ignored.
- DRAIN:
  - Pads are tristated (oeb=1, out=0) and the old design is in reset.
  - When the counter reaches 0: load active <= current synced sel, reload counter, go to SETTLE.
  - If sel reverts to the old index during DRAIN, the block still completes the switch cycle, landing on that index.
- !lock_ok in SETTLE or DRAIN: go to HALT on the next edge.
- Asynchronous reset mid-switch: returns immediately to the reset values.
- Non-active designs always see o_dsn_in = 0 and o_dsn_reset = 1.
- Switch cost: a switch takes exactly 2*GUARD_CYCLES + 1 clocks from the first DRAIN cycle to the first ACTIVE cycle.
- Startup cost: the first ACTIVE cycle occurs SYNC_STAGES + GUARD_CYCLES + 1 clocks after lock_ok and a valid sel are applied.

Optional Feature:
- Macro: EW_PAD_MUX_LOOPBACK_EN.
- When defined:
  - sel == NUM_DESIGNS is a valid index selecting a loopback test mode, entered through the same DRAIN/SETTLE sequence.
  - In loopback, o_pad_oeb = {PADS/2 ones in the upper bits, remaining zeros}.
  - For every output pad i, o_pad_out[i] = i_pad_in[i + PADS - PADS/2], delayed by one register stage. Low pad i echoes upper pad i + PADS - PADS/2, so no pad ever loops back to itself.
  - All designs are held in reset while in loopback.
- When undefined: sel == NUM_DESIGNS is out of range and ignored.

Decomposition:
- Package ew_pad_mux_pkg holds:
  - state enum {HALT, SETTLE, ACTIVE, DRAIN};
  - SEL_W computation function;
  - loopback index constant.
- Sub-module ew_sync: parametrised SYNC_STAGES synchroniser, instantiated per control bit, async active-low reset.

Test Plan:
1. Reset then lock_a=1, lock_b=0, sel=2 (defaults) -> HALT for SYNC_STAGES, 8 SETTLE cycles, then ACTIVE at clk 11 after apply. o_dsn_reset=4'b1011, pads follow design 2 combinationally, o_active=2.
2. ACTIVE on design 2, sel->1 -> o_dsn_reset[2]=1 and pads tristated for 17 clocks. Then design 1 drives the pads, o_dsn_reset=4'b1101, o_dsn_in slice 2 = 0.
3. ACTIVE, set lock_b=lock_a=1 -> HALT within SYNC_STAGES+1 clocks, all resets 1, oeb=9'h1FF. Then re-open the lock -> full SETTLE before ACTIVE.
4. sel=7 (out of range, loopback undefined) in ACTIVE and in HALT -> state unchanged, no reset pulse on any design.
5. Deassert i_reset_n during DRAIN at counter=3 -> same-cycle all outputs at reset values. After release, the block re-enters HALT and obeys the startup timing.
6. With EW_PAD_MUX_LOOPBACK_EN, sel=4 -> oeb=9'b111100000. Driving i_pad_in[8:5]=4'b1010 gives o_pad_out[3:0]=4'b1010 one clock later, with all designs in reset.

Source files
------------

// File: rtl/ew_pad_mux_pkg.sv
// Shared types and helpers for the ew_pad_mux pad-sharing block.
package ew_pad_mux_pkg;

    typedef enum logic [1:0] {
        HALT   = 2'd0,
        SETTLE = 2'd1,
        ACTIVE = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    function automatic int sel_width(input int num_designs);
        return $clog2(num_designs + 1);
    endfunction

    // The loopback mode sits one index past the last real design.
    function automatic int loopback_index(input int num_designs);
        return num_designs;
    endfunction

endpackage

// File: rtl/ew_sync.sv
// Single-bit multi-stage synchroniser with asynchronous active-low reset.
module ew_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_r;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_r <= '0;
        end else begin
            chain_r <= {chain_r[STAGES-2:0], d};
        end
    end

    assign q = chain_r[STAGES-1];

endmodule

// File: rtl/ew_pad_mux.sv
// Glitch-free pad sharing between NUM_DESIGNS user designs with guarded switching.
// Optional loopback test mode: define EW_PAD_MUX_LOOPBACK_EN.
module ew_pad_mux
    import ew_pad_mux_pkg::*;
#(
    parameter int NUM_DESIGNS  = 4,
    parameter int PADS         = 9,
    parameter int GUARD_CYCLES = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int SEL_W        = sel_width(NUM_DESIGNS)
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic                        i_la_invalid,
    input  logic                        i_sel_lock_a,
    input  logic                        i_sel_lock_b,
    input  logic [SEL_W-1:0]            i_sel,
    input  logic [PADS-1:0]             i_pad_in,
    output logic [PADS-1:0]             o_pad_out,
    output logic [PADS-1:0]             o_pad_oeb,
    input  logic [NUM_DESIGNS*PADS-1:0] i_dsn_out,
    input  logic [NUM_DESIGNS*PADS-1:0] i_dsn_oeb,
    output logic [NUM_DESIGNS*PADS-1:0] o_dsn_in,
    output logic [NUM_DESIGNS-1:0]      o_dsn_reset,
    output logic [SEL_W-1:0]            o_active,
    output logic                        o_switching
);

    localparam int                CNT_W      = $clog2(GUARD_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_FIRST  = CNT_W'(GUARD_CYCLES - 1);
    // The post-drain settle runs one clock longer so a full switch costs 2*GUARD+1.
    localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(GUARD_CYCLES);
    localparam logic [SEL_W-1:0]  LB_SEL     = SEL_W'(loopback_index(NUM_DESIGNS));

    logic              la_invalid_s;
    logic              lock_a_s;
    logic              lock_b_s;
    logic [SEL_W-1:0]  sel_s;
    logic              lock_ok_s;
    logic              sel_ok_s;

    state_t                 state_r;
    logic [SEL_W-1:0]       active_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [NUM_DESIGNS-1:0] dsn_reset_r;
    logic [NUM_DESIGNS-1:0] release_s;
    logic [PADS-1:0]        pad_out_s;
    logic [PADS-1:0]        pad_oeb_s;
    logic [NUM_DESIGNS*PADS-1:0] dsn_in_s;

    ew_sync #(.STAGES(SYNC_STAGES)) u_sync_invalid (
        .clk(i_clk), .rst_n(i_reset_n), .d(i_la_invalid), .q(la_invalid_s)
    );
    ew_sync #(.STAGES(SYNC_STAGES)) u_sync_lock_a (
        .clk(i_clk), .rst_n(i_reset_n), .d(i_sel_lock_a), .q(lock_a_s)
    );
    ew_sync #(.STAGES(SYNC_STAGES)) u_sync_lock_b (
        .clk(i_clk), .rst_n(i_reset_n), .d(i_sel_lock_b), .q(lock_b_s)
    );

    for (genvar b = 0; b < SEL_W; b++) begin : g_sel_sync
        ew_sync #(.STAGES(SYNC_STAGES)) u_sync_sel (
            .clk(i_clk), .rst_n(i_reset_n), .d(i_sel[b]), .q(sel_s[b])
        );
    end

    assign lock_ok_s = (lock_a_s != lock_b_s) && !la_invalid_s;

`ifdef EW_PAD_MUX_LOOPBACK_EN
    assign sel_ok_s = (sel_s <= LB_SEL);

    logic [PADS-1:0] loop_r;

    // Low pads echo the upper pads one clock late; never a pad onto itself.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            loop_r <= '0;
        end else begin
            loop_r <= i_pad_in >> (PADS - PADS / 2);
        end
    end
`else
    assign sel_ok_s = (sel_s < LB_SEL);
`endif

    // Reset mask applied on entry to ACTIVE: only the selected real design runs.
    always_comb begin
        release_s = '1;
        for (int d = 0; d < NUM_DESIGNS; d++) begin
            if (active_r == SEL_W'(d)) begin
                release_s[d] = 1'b0;
            end else begin
                release_s[d] = 1'b1;
            end
        end
    end

    // Switch sequencer: HALT -> SETTLE -> ACTIVE -> DRAIN -> SETTLE ...
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r     <= HALT;
            active_r    <= '0;
            cnt_r       <= '0;
            dsn_reset_r <= '1;
        end else begin
            case (state_r)
                HALT: begin
                    dsn_reset_r <= '1;
                    if (lock_ok_s && sel_ok_s) begin
                        active_r <= sel_s;
                        cnt_r    <= CNT_FIRST;
                        state_r  <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (!lock_ok_s) begin
                        state_r     <= HALT;
                        dsn_reset_r <= '1;
                    end else if (cnt_r == '0) begin
                        state_r     <= ACTIVE;
                        dsn_reset_r <= release_s;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ACTIVE: begin
                    if (!lock_ok_s) begin
                        state_r     <= HALT;
                        dsn_reset_r <= '1;
                    end else if (sel_ok_s && (sel_s != active_r)) begin
                        state_r     <= DRAIN;
                        dsn_reset_r <= '1;
                        cnt_r       <= CNT_FIRST;
                    end
                end
                DRAIN: begin
                    if (!lock_ok_s) begin
                        state_r <= HALT;
                    end else if (cnt_r == '0) begin
                        if (sel_ok_s) begin
                            active_r <= sel_s;
                        end
                        cnt_r   <= CNT_RELOAD;
                        state_r <= SETTLE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    state_r     <= HALT;
                    dsn_reset_r <= '1;
                end
            endcase
        end
    end

    // Pad routing depends only on registered state, so it cannot glitch mid-switch.
    always_comb begin
        pad_out_s = '0;
        pad_oeb_s = '1;
        dsn_in_s  = '0;
        if (state_r == ACTIVE) begin
            for (int d = 0; d < NUM_DESIGNS; d++) begin
                if (active_r == SEL_W'(d)) begin
                    pad_out_s              = i_dsn_out[d*PADS +: PADS];
                    pad_oeb_s              = i_dsn_oeb[d*PADS +: PADS];
                    dsn_in_s[d*PADS +: PADS] = i_pad_in;
                end else begin
                    dsn_in_s[d*PADS +: PADS] = '0;
                end
            end
`ifdef EW_PAD_MUX_LOOPBACK_EN
            if (active_r == LB_SEL) begin
                pad_out_s = loop_r;
                pad_oeb_s = ~({PADS{1'b1}} >> (PADS / 2));
            end else begin
                pad_out_s = pad_out_s;
            end
`endif
        end else begin
            pad_out_s = '0;
        end
    end

    assign o_pad_out   = pad_out_s;
    assign o_pad_oeb   = pad_oeb_s;
    assign o_dsn_in    = dsn_in_s;
    assign o_dsn_reset = dsn_reset_r;
    assign o_active    = active_r;
    assign o_switching = (state_r != ACTIVE);

endmodule
